// File: rtl/pipelined_decode_controller_if.sv
// Handshake bundle between the ID stage front end and the decode controller.
// The controller side is the slave and the front end/EX side is the master.
interface pipelined_decode_controller_if;
    logic       INSTR_VALID;
    logic [6:0] OPCODE;
    logic [2:0] FUNC3;
    logic [6:0] FUNC7;
    logic       STALL_IN;
    logic       FLUSH;
    logic       EX_VALID;
    logic [4:0] ALU_OP;
    logic [2:0] IMM_SEL;
    logic [1:0] BJ_CTRL;
    logic [1:0] WB_VALUE_SEL;
    logic       REG_WRITE_EN;
    logic       MEM_READ_EN;
    logic       MEM_WRITE_EN;
    logic       COMP_SEL;
    logic       OP2_SEL;
    logic       OP1_SEL;
    logic       MD_BUSY;
    logic       MD_DONE;
    logic       STALL_OUT;
    logic       ILLEGAL_INSTR;

    modport slave (
        input  INSTR_VALID, OPCODE, FUNC3, FUNC7, STALL_IN, FLUSH,
        output EX_VALID, ALU_OP, IMM_SEL, BJ_CTRL, WB_VALUE_SEL, REG_WRITE_EN, MEM_READ_EN,
               MEM_WRITE_EN, COMP_SEL, OP2_SEL, OP1_SEL, MD_BUSY, MD_DONE, STALL_OUT,
               ILLEGAL_INSTR
    );

    modport master (
        output INSTR_VALID, OPCODE, FUNC3, FUNC7, STALL_IN, FLUSH,
        input  EX_VALID, ALU_OP, IMM_SEL, BJ_CTRL, WB_VALUE_SEL, REG_WRITE_EN, MEM_READ_EN,
               MEM_WRITE_EN, COMP_SEL, OP2_SEL, OP1_SEL, MD_BUSY, MD_DONE, STALL_OUT,
               ILLEGAL_INSTR
    );
endinterface

// File: rtl/pipelined_decode_controller.sv
// RV32IM decode controller: ID-stage decode feeding a registered ID/EX control word,
// with a busy FSM that holds EX and back-pressures IF/ID during multi-cycle M-ops.
module pipelined_decode_controller #(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_LATENCY = 32,
    parameter bit          ENABLE_M    = 1'b1,
    parameter int unsigned CNT_W       = $clog2(DIV_LATENCY + 1)
) (
    input logic                           CLK,
    input logic                           RESET_N,
    pipelined_decode_controller_if.slave  bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] alu_op;
        logic [2:0] imm_sel;
        logic [1:0] bj;
        logic [1:0] wb;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       comp;
        logic       op2;
        logic       op1;
        logic       mop;
    } ctrl_t;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    ctrl_t             r_ex_q, w_ex_d, w_dec;
    logic              r_ill_q, w_ill_d;
    state_e            r_state_q, w_state_d;
    logic [CNT_W-1:0]  r_cnt_q, w_cnt_d, w_lat_m1;
    logic              w_legal, w_multi, w_busy, w_hold_md, w_stall_out, w_issue;

    always_comb begin
        w_dec   = '0;
        w_legal = 1'b1;
        unique case (bus.OPCODE)
            7'b0110111: begin w_dec.alu_op = 5'b11111; w_dec.imm_sel = 3'd3;
                              w_dec.op2 = 1'b1; w_dec.rw = 1'b1; end
            7'b0010111: begin w_dec.imm_sel = 3'd3; w_dec.op1 = 1'b1; w_dec.op2 = 1'b1;
                              w_dec.rw = 1'b1; end
            7'b1101111: begin w_dec.imm_sel = 3'd1; w_dec.bj = 2'b01; w_dec.op1 = 1'b1;
                              w_dec.op2 = 1'b1; w_dec.wb = 2'd2; w_dec.rw = 1'b1; end
            7'b1100111: begin w_dec.imm_sel = 3'd4; w_dec.bj = 2'b01; w_dec.op2 = 1'b1;
                              w_dec.wb = 2'd2; w_dec.rw = 1'b1; end
            7'b1100011: begin w_dec.bj = 2'b10; w_dec.comp = 1'b1; end
            7'b0000011: begin w_dec.imm_sel = 3'd4; w_dec.op2 = 1'b1; w_dec.mr = 1'b1;
                              w_dec.wb = 2'd1; w_dec.rw = 1'b1; end
            7'b0100011: begin w_dec.imm_sel = 3'd2; w_dec.op2 = 1'b1; w_dec.mw = 1'b1; end
            7'b0010011: begin
                w_dec.alu_op  = {1'b0, (bus.FUNC3 == 3'b101) ? bus.FUNC7[5] : 1'b0, bus.FUNC3};
                w_dec.imm_sel = 3'd4;
                w_dec.op2     = 1'b1;
                w_dec.rw      = 1'b1;
            end
            7'b0110011: begin
                w_dec.alu_op = {bus.FUNC7[0], bus.FUNC7[5], bus.FUNC3};
                w_dec.rw     = 1'b1;
                case (bus.FUNC7)
                    7'b0000000: ;
                    7'b0100000: w_legal = (bus.FUNC3 == 3'b000) || (bus.FUNC3 == 3'b101);
                    7'b0000001: begin w_legal = ENABLE_M; w_dec.mop = ENABLE_M; end
                    default:    w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        w_dec.valid = 1'b1;
    end

    // FUNC3[2] separates the divide group from the multiply group.
    assign w_lat_m1 = bus.FUNC3[2] ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
    assign w_multi  = w_dec.mop & (bus.FUNC3[2] ? (DIV_LATENCY > 1) : (MUL_LATENCY > 1));

    assign w_busy      = (r_state_q == StBusy);
    assign w_hold_md   = w_busy & (r_cnt_q != '0);
    assign w_stall_out = w_hold_md;
    assign w_issue     = bus.INSTR_VALID & ~bus.STALL_IN & ~bus.FLUSH & ~w_stall_out;

    always_comb begin
        w_ex_d    = r_ex_q;
        w_ill_d   = 1'b0;
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        if (bus.FLUSH) begin
            w_ex_d    = '0;
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else if (bus.STALL_IN || w_hold_md) begin
            // ID/EX frozen; the latency counter keeps running underneath a stall.
            if (w_hold_md) w_cnt_d = r_cnt_q - 1'b1;
        end else if (w_issue) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            if (w_legal) begin
                w_ex_d = w_dec;
                if (w_multi) begin
                    w_state_d = StBusy;
                    w_cnt_d   = w_lat_m1;
                end
            end else begin
                w_ex_d  = '0;
                w_ill_d = 1'b1;
            end
        end else begin
            w_ex_d    = '0;
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ex_q    <= '0;
            r_ill_q   <= 1'b0;
            r_state_q <= StIdle;
            r_cnt_q   <= '0;
        end else begin
            r_ex_q    <= w_ex_d;
            r_ill_q   <= w_ill_d;
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign bus.EX_VALID      = r_ex_q.valid;
    assign bus.ALU_OP        = r_ex_q.alu_op;
    assign bus.IMM_SEL       = r_ex_q.imm_sel;
    assign bus.BJ_CTRL       = r_ex_q.bj;
    assign bus.WB_VALUE_SEL  = r_ex_q.wb;
    assign bus.REG_WRITE_EN  = r_ex_q.rw;
    assign bus.MEM_READ_EN   = r_ex_q.mr;
    assign bus.MEM_WRITE_EN  = r_ex_q.mw;
    assign bus.COMP_SEL      = r_ex_q.comp;
    assign bus.OP2_SEL       = r_ex_q.op2;
    assign bus.OP1_SEL       = r_ex_q.op1;
    assign bus.MD_BUSY       = w_busy;
    assign bus.STALL_OUT     = w_stall_out;
    // An M-op resident while idle is a single-cycle op, so it is done immediately.
    assign bus.MD_DONE       = r_ex_q.valid & r_ex_q.mop & (~w_busy | (r_cnt_q == '0));
    assign bus.ILLEGAL_INSTR = r_ill_q;

endmodule

// File: doc/pipelined_decode_controller.md
Name: pipelined_decode_controller

Overview:
- Registered, stall-aware successor to the combinational RV32IM controller.
- Decodes OPCODE/FUNC3/FUNC7 in ID and drives the ID/EX control register.
- Sequences multi-cycle M-extension ops with a busy FSM that back-pressures the front end.
- Handles pipeline stall, flush, bubble insertion and illegal-instruction flagging.

Parameters:
- MUL_LATENCY, 2, EX cycles occupied by MUL/MULH/MULHSU/MULHU (>=1)
- DIV_LATENCY, 32, EX cycles occupied by DIV/DIVU/REM/REMU (>=1, >=MUL_LATENCY)
- ENABLE_M, 1, 0 makes FUNC7=0000001 R-type illegal
- CNT_W, $clog2(DIV_LATENCY+1), latency counter width

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- INSTR_VALID  in  1  ID holds a valid instruction
- OPCODE  in  7  instruction opcode
- FUNC3  in  3  funct3
- FUNC7  in  7  funct7
- STALL_IN  in  1  downstream hazard stall; hold ID/EX
- FLUSH  in  1  squash ID/EX contents (branch/jump taken)
- EX_VALID  out  1  ID/EX holds a real instruction
- ALU_OP  out  5  ALU operation
- IMM_SEL  out  3  0=B 1=J 2=S 3=U 4=I
- BJ_CTRL  out  2  00 none, 01 jump, 10 branch
- WB_VALUE_SEL  out  2  0=ALU 1=MEM 2=PC+4
- REG_WRITE_EN, MEM_READ_EN, MEM_WRITE_EN, COMP_SEL, OP2_SEL, OP1_SEL  out  1 each  as in current controller
- MD_BUSY  out  1  multi-cycle op in progress
- MD_DONE  out  1  final EX cycle of a multi-cycle op
- STALL_OUT  out  1  freeze IF/ID
- ILLEGAL_INSTR  out  1  one-cycle pulse: issued instruction undecodable

Behaviour:
- Reset (RESET_N=0, async): every output 0, FSM IDLE, counter 0. Reset beats all inputs.
- Decode table (combinational, ID):
  - LUI: ALU_OP 11111, IMM 3, OP2=1, WB 0, RW=1
  - AUIPC: ALU 0, IMM 3, OP1=OP2=1, RW=1
  - JAL: IMM 1, BJ 01, OP1=OP2=1, WB 2, RW=1
  - JALR: IMM 4, BJ 01, OP2=1, WB 2, RW=1
  - Branch: IMM 0, BJ 10, COMP_SEL=1, RW=0
  - Load: IMM 4, OP2=1, MEM_READ=1, WB 1, RW=1
  - Store: IMM 2, OP2=1, MEM_WRITE=1, RW=0
  - OP-IMM: ALU {0, FUNC3==101 ? FUNC7[5] : 0, FUNC3}, IMM 4, OP2=1, RW=1
  - OP: ALU {FUNC7[0], FUNC7[5], FUNC3}, OP2=0, RW=1
  - Unspecified fields 0.
- Illegal: any other opcode; OP with FUNC7 not in {0000000, 0000001, 0100000}; 0100000 with FUNC3 not in {000, 101}; 0000001 when ENABLE_M=0.
- Issue condition: INSTR_VALID & ~STALL_IN & ~FLUSH & ~STALL_OUT. Legal issue loads decoded fields, EX_VALID=1 next cycle (1-cycle latency).
- Per-cycle priority, highest first:
  1. FLUSH: next cycle bubble, FSM to IDLE, counter 0, MD_DONE 0.
  2. STALL_IN: all registered outputs hold. FSM counter still decrements.
  3. Issue.
  4. Otherwise bubble.
- Bubble: EX_VALID, all enables, BJ_CTRL and all fields 0.
- Illegal issue: bubble loaded; ILLEGAL_INSTR=1 for exactly that next cycle.
- M-op (OP, FUNC7=0000001):
  - LAT = FUNC3[2] ? DIV_LATENCY : MUL_LATENCY.
  - LAT>1: FSM to MD_BUSY, counter = LAT-1.
  - In MD_BUSY: counter decrements each cycle, ID/EX holds the M-op (EX_VALID=1).
  - MD_BUSY=1 while in MD_BUSY.
  - STALL_OUT = MD_BUSY & counter!=0.
  - When counter==0: MD_DONE=1, STALL_OUT=0, a new instruction may issue that cycle; FSM to IDLE, or re-enters MD_BUSY if the new issue is an M-op.
  - LAT==1: no busy state, MD_DONE=1 in its single EX cycle.
  - Total EX occupancy = LAT cycles.
- MD_DONE and counter==0 coinciding with STALL_IN: MD_DONE stays 1 and outputs hold until STALL_IN drops; FSM then returns to IDLE.
- RESET_N low mid-MD_BUSY: immediate abort, all outputs 0.

Test Plan:
- Reset, then issue ADDI (0010011/000) → next cycle EX_VALID=1, ALU_OP=00000, IMM_SEL=4, OP2_SEL=1, REG_WRITE_EN=1, STALL_OUT=0.
- SUB (0110011/000/0100000) then STALL_IN=1 for 3 cycles with LW presented → ALU_OP=01000 held 3 cycles; LW appears cycle after STALL_IN drops (MEM_READ_EN=1, WB_VALUE_SEL=1).
- MUL, MUL_LATENCY=2 → EX cycle1 MD_BUSY=1, STALL_OUT=1; cycle2 MD_DONE=1, STALL_OUT=0; following ADD issues and appears cycle3.
- DIV, DIV_LATENCY=32 → STALL_OUT high exactly 31 cycles, MD_DONE pulses on the 32nd cycle; FLUSH at cycle 10 → bubble next cycle, MD_BUSY=0, STALL_OUT=0.
- Opcode 1111111, and OP with FUNC7=0000010 → ILLEGAL_INSTR 1-cycle pulse each, EX_VALID=0, REG_WRITE_EN=0.
- RESET_N asserted mid-DIV (count=15) → all outputs 0 without waiting for a clock edge; after release, ADDI issues normally.
